// File: rtl/supernova_pkg.sv
// Shared types for the architectural register file checkpoint engine.
// Command encodings, controller states and the default slot count live here.
package supernova_pkg;

    localparam int DEFAULT_NUM_CKPT = 4;

    typedef enum logic [1:0] {
        CK_SAVE       = 2'd0,
        CK_RESTORE    = 2'd1,
        CK_INVALIDATE = 2'd2,
        CK_RSVD       = 2'd3
    } ck_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_RESTORE = 2'd2,
        ST_DONE    = 2'd3
    } ck_state_e;

endpackage

// File: rtl/supernova_arf_ckpt_ctrl.sv
// Checkpoint controller: command decode, copy sequencing and per-slot valid bits.
// The copy index walks one GPR/FPR pair per cycle; storage is owned by the parent.
module supernova_arf_ckpt_ctrl
    import supernova_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_CKPT = DEFAULT_NUM_CKPT,
    localparam int AW = $clog2(NUM_REGS),
    localparam int SW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ck_cmd_valid,
    output logic                ck_cmd_ready,
    input  logic [1:0]          ck_cmd_op,
    input  logic [SW-1:0]       ck_cmd_slot,
    output logic                ck_done,
    output logic                ck_err,
    output logic [NUM_CKPT-1:0] ck_slot_valid,
    output logic                commit_stall,
    output logic                save_en_o,
    output logic                restore_en_o,
    output logic [AW-1:0]       copy_idx_o,
    output logic [SW-1:0]       copy_slot_o,
    output ck_state_e           state_o
);

    ck_state_e           state_q, state_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic                err_q, err_d;
    logic [NUM_CKPT-1:0] valid_q, valid_d;
    logic                slot_ok;
    logic                last_idx;

    assign slot_ok  = (32'(ck_cmd_slot) < NUM_CKPT);
    assign last_idx = (idx_q == AW'(NUM_REGS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            slot_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        err_d   = err_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (ck_cmd_valid && !rst) begin
                    slot_d = ck_cmd_slot;
                    idx_d  = '0;
                    err_d  = 1'b0;
                    if (!slot_ok) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        case (ck_op_e'(ck_cmd_op))
                            CK_SAVE: begin
                                // Slot must not look restorable while half-written.
                                valid_d[ck_cmd_slot] = 1'b0;
                                state_d              = ST_SAVE;
                            end
                            CK_RESTORE: begin
                                if (valid_q[ck_cmd_slot]) begin
                                    state_d = ST_RESTORE;
                                end else begin
                                    err_d   = 1'b1;
                                    state_d = ST_DONE;
                                end
                            end
                            CK_INVALIDATE: begin
                                valid_d[ck_cmd_slot] = 1'b0;
                                state_d              = ST_DONE;
                            end
                            default: begin
                                err_d   = 1'b1;
                                state_d = ST_DONE;
                            end
                        endcase
                    end
                end
            end
            ST_SAVE: begin
                idx_d = idx_q + AW'(1);
                if (last_idx) begin
                    valid_d[slot_q] = 1'b1;
                    state_d         = ST_DONE;
                end
            end
            ST_RESTORE: begin
                idx_d = idx_q + AW'(1);
                if (last_idx) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and status outputs are forced quiet while reset is held.
    assign ck_cmd_ready  = (state_q == ST_IDLE) && !rst;
    assign ck_done       = (state_q == ST_DONE) && !rst;
    assign ck_err        = ck_done && err_q;
    assign commit_stall  = (state_q != ST_IDLE) && !rst;
    assign ck_slot_valid = valid_q;
    assign save_en_o     = (state_q == ST_SAVE);
    assign restore_en_o  = (state_q == ST_RESTORE);
    assign copy_idx_o    = idx_q;
    assign copy_slot_o   = slot_q;
    assign state_o       = state_q;

endmodule

// File: rtl/supernova_arf_ckpt.sv
// Architectural GPR/FPR files with multi-lane commit writes, combinational reads
// and a slot-based checkpoint store driven by supernova_arf_ckpt_ctrl.
module supernova_arf_ckpt
    import supernova_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int XLEN         = 64,
    parameter int COMMIT_WIDTH = 4,
    parameter int NUM_RD       = 2,
    parameter int NUM_CKPT     = DEFAULT_NUM_CKPT,
    localparam int AW = $clog2(NUM_REGS),
    localparam int SW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [COMMIT_WIDTH-1:0]      cmt_gpr_we,
    input  logic [COMMIT_WIDTH*AW-1:0]   cmt_gpr_addr,
    input  logic [COMMIT_WIDTH*XLEN-1:0] cmt_gpr_data,
    input  logic [COMMIT_WIDTH-1:0]      cmt_fpr_we,
    input  logic [COMMIT_WIDTH*AW-1:0]   cmt_fpr_addr,
    input  logic [COMMIT_WIDTH*XLEN-1:0] cmt_fpr_data,
    output logic                         commit_stall,
    input  logic [NUM_RD*AW-1:0]         rd_gpr_addr,
    output logic [NUM_RD*XLEN-1:0]       rd_gpr_data,
    input  logic [NUM_RD*AW-1:0]         rd_fpr_addr,
    output logic [NUM_RD*XLEN-1:0]       rd_fpr_data,
    input  logic                         ck_cmd_valid,
    output logic                         ck_cmd_ready,
    input  logic [1:0]                   ck_cmd_op,
    input  logic [SW-1:0]                ck_cmd_slot,
    output logic                         ck_done,
    output logic                         ck_err,
    output logic [NUM_CKPT-1:0]          ck_slot_valid
);

    logic [XLEN-1:0] gpr_q      [NUM_REGS];
    logic [XLEN-1:0] fpr_q      [NUM_REGS];
    logic [XLEN-1:0] ckpt_gpr_q [NUM_CKPT][NUM_REGS];
    logic [XLEN-1:0] ckpt_fpr_q [NUM_CKPT][NUM_REGS];

    logic          save_en;
    logic          restore_en;
    logic [AW-1:0] copy_idx;
    logic [SW-1:0] copy_slot;
    ck_state_e     ck_state;

    supernova_arf_ckpt_ctrl #(
        .NUM_REGS (NUM_REGS),
        .NUM_CKPT (NUM_CKPT)
    ) u_ctrl (
        .clk           (clk),
        .rst           (rst),
        .ck_cmd_valid  (ck_cmd_valid),
        .ck_cmd_ready  (ck_cmd_ready),
        .ck_cmd_op     (ck_cmd_op),
        .ck_cmd_slot   (ck_cmd_slot),
        .ck_done       (ck_done),
        .ck_err        (ck_err),
        .ck_slot_valid (ck_slot_valid),
        .commit_stall  (commit_stall),
        .save_en_o     (save_en),
        .restore_en_o  (restore_en),
        .copy_idx_o    (copy_idx),
        .copy_slot_o   (copy_slot),
        .state_o       (ck_state)
    );

    // Later lanes are assigned last, so the highest lane wins on address collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                gpr_q[i] <= '0;
                fpr_q[i] <= '0;
            end
        end else if (restore_en) begin
            gpr_q[copy_idx] <= ckpt_gpr_q[copy_slot][copy_idx];
            fpr_q[copy_idx] <= ckpt_fpr_q[copy_slot][copy_idx];
        end else if (!commit_stall) begin
            for (int l = 0; l < COMMIT_WIDTH; l++) begin
                if (cmt_gpr_we[l] && (cmt_gpr_addr[l*AW +: AW] != '0)) begin
                    gpr_q[cmt_gpr_addr[l*AW +: AW]] <= cmt_gpr_data[l*XLEN +: XLEN];
                end
                if (cmt_fpr_we[l]) begin
                    fpr_q[cmt_fpr_addr[l*AW +: AW]] <= cmt_fpr_data[l*XLEN +: XLEN];
                end
            end
        end
    end

    // Slot contents are meaningless until their valid bit is set, so no reset here.
    always_ff @(posedge clk) begin
        if (save_en) begin
            ckpt_gpr_q[copy_slot][copy_idx] <= gpr_q[copy_idx];
            ckpt_fpr_q[copy_slot][copy_idx] <= fpr_q[copy_idx];
        end
    end

    always_comb begin
        rd_gpr_data = '0;
        rd_fpr_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (rd_gpr_addr[r*AW +: AW] != '0) begin
                rd_gpr_data[r*XLEN +: XLEN] = gpr_q[rd_gpr_addr[r*AW +: AW]];
            end
            rd_fpr_data[r*XLEN +: XLEN] = fpr_q[rd_fpr_addr[r*AW +: AW]];
        end
    end

    commit_while_busy: assert property (@(posedge clk) disable iff (rst)
        (ck_state != ST_IDLE) |-> (!(|cmt_gpr_we) && !(|cmt_fpr_we)))
        else $error("commit write presented while checkpoint engine busy");

endmodule

// File: doc/supernova_arf_ckpt.md
SUPERNOVA_ARF_CKPT -- requirements
Module: supernova_arf_ckpt

Interface
REQ-001 SHALL provide parameter NUM_REGS, default 32, meaning architectural registers per file (GPR and FPR); AW = clog2(NUM_REGS).
REQ-002 SHALL provide parameter XLEN, default 64, meaning register data width.
REQ-003 SHALL provide parameter COMMIT_WIDTH, default 4, meaning commit write lanes per file.
REQ-004 SHALL provide parameter NUM_RD, default 2, meaning read ports per file.
REQ-005 SHALL provide parameter NUM_CKPT, default 4, meaning checkpoint slots; SW = max(1, clog2(NUM_CKPT)).
REQ-006 SHALL have one clock and a synchronous, active-high reset, with ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports cmt_gpr_we  in  COMMIT_WIDTH  per-lane GPR write enable; cmt_gpr_addr  in  COMMIT_WIDTH x AW  lane address; cmt_gpr_data  in  COMMIT_WIDTH x XLEN  lane data.
REQ-008 SHALL have ports cmt_fpr_we, cmt_fpr_addr and cmt_fpr_data, identical in shape to the GPR commit ports.
REQ-009 SHALL have port commit_stall  out  1  high while the checkpoint engine is busy.
REQ-010 SHALL have ports rd_gpr_addr  in  NUM_RD x AW; rd_gpr_data  out  NUM_RD x XLEN; rd_fpr_addr  in  NUM_RD x AW; rd_fpr_data  out  NUM_RD x XLEN.
REQ-011 SHALL have ports ck_cmd_valid  in  1; ck_cmd_ready  out  1; ck_cmd_op  in  2  (ck_op_e); ck_cmd_slot  in  SW.
REQ-012 SHALL have ports ck_done  out  1  one-cycle completion pulse; ck_err  out  1  error qualifier, valid with ck_done; ck_slot_valid  out  NUM_CKPT  per-slot valid.

Function
REQ-013 SHALL return combinational read data; GPR address 0 reads zero; FPR 0 is ordinary; reads SHALL return pre-write (registered) state with no same-cycle bypass.
REQ-014 SHALL apply commit writes at the clock edge; GPR writes to address 0 are discarded.
REQ-015 SHALL resolve multiple lanes writing the same address in one cycle so that the highest lane index wins.
REQ-016 SHALL implement FSM states IDLE, SAVE, RESTORE and DONE; ck_cmd_ready = 1 only in IDLE and not in reset.
REQ-017 SHALL accept a command on ck_cmd_valid & ck_cmd_ready; the commit writes of the accept cycle still apply and are included in a SAVE snapshot.
REQ-018 SHALL handle SAVE(op 0) as follows: set copy index to 0 → SAVE; each cycle copy GPR[i] and FPR[i] to the slot; after index NUM_REGS-1, set ck_slot_valid[slot] and go → DONE (latency NUM_REGS+1 cycles from accept to ck_done).
REQ-019 SHALL handle RESTORE(op 1) of a valid slot by copying the slot into the ARF at one register pair per cycle → DONE (same latency); the slot stays valid.
REQ-020 SHALL handle RESTORE of an invalid slot, or op 3 (reserved), by going directly → DONE with ck_err=1 and leaving the ARF and the slots unchanged.
REQ-021 SHALL handle INVALIDATE(op 2) by clearing ck_slot_valid[slot] and going → DONE with ck_err=0.
REQ-022 SHALL treat a slot index ≥ NUM_CKPT as ck_err=1 with no state change.
REQ-023 SHALL make DONE last one cycle, with ck_done=1 and then → IDLE; a back-to-back command is accepted no earlier than the cycle after DONE.
REQ-024 SHALL drive commit_stall=1 in SAVE, RESTORE and DONE; commit writes presented while commit_stall=1 are dropped (upstream obligation, asserted in simulation).
REQ-025 SHALL keep the slot of a SAVE invalid until the SAVE completes; a SAVE over a valid slot clears its valid bit in the accept cycle.

Reset
REQ-026 SHALL, on rst, clear all GPR and FPR entries to 0, clear ck_slot_valid, put the FSM in IDLE and drive ck_done=0, ck_err=0, commit_stall=0 and ck_cmd_ready=0 during reset.
REQ-027 SHALL, on rst asserted mid-SAVE/RESTORE, abort the operation with no ck_done; slot contents are don't-care and marked invalid.

Structure
REQ-028 SHALL place ck_op_e (SAVE, RESTORE, INVALIDATE, RSVD) and the default NUM_CKPT in supernova_pkg.
REQ-029 SHALL implement the FSM and copy counter in sub-module supernova_arf_ckpt_ctrl; the storage arrays stay in the top module.

Verification
REQ-030 SHALL cover: lanes 0 and 3 both write GPR5, with 0xA and 0xB → the next cycle GPR5 reads 0xB; a write of 0xFF to GPR0 → GPR0 reads 0.
REQ-031 SHALL cover: GPR7=0x77, SAVE slot 1, overwrite GPR7=0x99 after ck_done, RESTORE slot 1 → GPR7 reads 0x77 and ck_done arrives exactly 33 cycles after each accept.
REQ-032 SHALL cover: RESTORE slot 2 that was never saved → ck_done with ck_err=1 the cycle after accept; ARF unchanged.
REQ-033 SHALL cover: commit write of GPR3=0x5 in the SAVE accept cycle → the slot holds GPR3=0x5.
REQ-034 SHALL cover: rst asserted at copy index 10 of a SAVE to slot 0 → FSM in IDLE, ck_slot_valid=0, no ck_done, all registers read 0.
REQ-035 SHALL cover: INVALIDATE slot 1 after a SAVE, then RESTORE slot 1 → ck_err=1.
